// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end that shares one GCD engine between NREQ requesters.
// Optional abort-on-timeout path enabled by defining GCD_SCHED_TIMEOUT_EN.
module gcd_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*WIDTH-1:0]       req_a,
  input  logic [NREQ*WIDTH-1:0]       req_b,
  output logic [NREQ-1:0]             req_ready,
  output logic                        gcd_start,
  output logic [WIDTH-1:0]            gcd_a,
  output logic [WIDTH-1:0]            gcd_b,
  input  logic                        gcd_done,
  input  logic [WIDTH-1:0]            gcd_result,
  output logic                        resp_valid,
  output logic [$clog2(NREQ)-1:0]     resp_id,
  output logic [WIDTH-1:0]            resp_result,
  input  logic                        resp_ready,
  output logic                        busy
`ifdef GCD_SCHED_TIMEOUT_EN
  ,
  output logic                        resp_err
`endif
);

  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("gcd_rr_scheduler: unsupported NREQ/TIMEOUT");
  end

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high at the rising edge; req_ready is only raised in IDLE, resp_valid only in RESP.
  typedef enum logic [2:0] {S_IDLE, S_ZBYP, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_next;
  logic [IDW-1:0]   r_ptr, r_id, w_gnt, w_ptr_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_result, w_sel_a, w_sel_b;
  logic             w_found, w_grant, w_zero, w_tmo;

  always_comb begin : arb
    logic [IDW:0] v_sum;
    w_found = 1'b0;
    w_gnt   = '0;
    v_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (v_sum >= (IDW+1)'(NREQ)) v_sum = v_sum - (IDW+1)'(NREQ);
      if (!w_found && req_valid[v_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = v_sum[IDW-1:0];
      end
    end
  end

  assign w_sel_a   = req_a[int'(w_gnt)*WIDTH +: WIDTH];
  assign w_sel_b   = req_b[int'(w_gnt)*WIDTH +: WIDTH];
  assign w_zero    = (w_sel_a == '0) || (w_sel_b == '0);
  assign w_grant   = (r_state == S_IDLE) && w_found;
  assign w_ptr_nxt = (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;
  // Gated by rst so nothing is acknowledged while reset is held.
  assign req_ready = (w_grant && !rst) ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gnt) : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = w_zero ? S_ZBYP : S_ISSUE;
      S_ZBYP:  w_next = S_RESP;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (gcd_done || w_tmo) w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_id  <= w_gnt;
        r_ptr <= w_ptr_nxt;
      end
      // A zero operand short-circuits: gcd(0,x)=x and gcd(0,0)=0.
      if (r_state == S_ZBYP) r_result <= r_a | r_b;
      if (r_state == S_WAIT) begin
        if (gcd_done)   r_result <= gcd_result;
        else if (w_tmo) r_result <= '0;
      end
    end
  end

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Abort in the WAIT cycle that brings the count up to TIMEOUT.
  assign w_tmo    = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT-1));
  assign resp_err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_ZBYP || (r_state == S_WAIT && gcd_done)) r_err <= 1'b0;
      else if (w_tmo)                                          r_err <= 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign gcd_start   = (r_state == S_ISSUE);
  assign gcd_a       = r_a;
  assign gcd_b       = r_b;
  assign resp_valid  = (r_state == S_RESP);
  assign resp_id     = r_id;
  assign resp_result = r_result;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: doc/gcd_rr_scheduler.md
Name: gcd_rr_scheduler

Overview:
- Shares one GCD datapath/controller engine between NREQ independent requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and selects one requester round-robin.
- Drives the engine's start/operand inputs, waits for done, then returns the result tagged with the requester ID.
- Sits between client logic and the single GCD engine instance.

Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 8, operand/result width in bits
- TIMEOUT, 1023, max engine cycles before abort (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester operand pair valid
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B, same packing as req_a
- req_ready  output  NREQ  one-hot accept strobe
- gcd_start  output  1  one-cycle start pulse to the engine
- gcd_a  output  WIDTH  operand A to the engine, held from start until done
- gcd_b  output  WIDTH  operand B to the engine, held from start until done
- gcd_done  input  1  engine completion, sampled high for at least 1 cycle
- gcd_result  input  WIDTH  engine result, valid while gcd_done=1
- resp_valid  output  1  response valid
- resp_id  output  $clog2(NREQ)  index of the requester that owns the response
- resp_result  output  WIDTH  GCD value
- resp_ready  input  1  consumer accepts the response
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0. All outputs 0: req_ready, gcd_start, gcd_a, gcd_b, resp_valid, resp_id, resp_result, busy. An in-flight job is dropped silently. Engine results after reset are ignored until the next start.
- Arbitration:
  - In IDLE, search req_valid starting at rr_ptr, wrapping modulo NREQ. The first set bit g wins.
  - Grant: req_ready[g]=1 for exactly 1 cycle, combinational with IDLE and any req_valid set. The handshake completes that cycle.
  - Latch a=req_a[g], b=req_b[g], id=g. Set rr_ptr=(g+1) mod NREQ.
- Requester rules:
  - A requester must hold valid and operands stable until ready.
  - Deasserting valid before ready is allowed; that request is simply not taken.
- States:
  - IDLE -> ZBYP if the latched a==0 or b==0. Otherwise IDLE -> ISSUE.
  - ZBYP: result = a|b, so gcd(0,x)=x and gcd(0,0)=0. The engine is not started. Go to RESP. The engine must never see a zero operand.
  - ISSUE: gcd_start=1 for one cycle, gcd_a/gcd_b driven with the latched values. Go to WAIT.
  - WAIT: hold gcd_a/gcd_b. On gcd_done=1, capture gcd_result into resp_result and go to RESP. A gcd_done seen during ISSUE is ignored.
  - RESP: resp_valid=1; resp_id and resp_result stay stable until resp_ready. On resp_valid & resp_ready, go to IDLE.
- Arbitration timing: no new grant until the IDLE state is re-entered. Minimum spacing between grants is therefore 3 cycles (bypass path) or engine latency + 3 cycles.
- Latency: grant -> resp_valid is 2 cycles via the bypass, or 2 + engine cycles via the engine.
- Fairness: with all requesters continuously valid, grants go 0,1,...,NREQ-1,0,... A requester waits at most NREQ-1 jobs.
- Simultaneous events:
  - resp_ready may already be high when RESP is entered; the response is accepted in that first RESP cycle.
  - req_valid edges arriving during a busy state are not acknowledged.
- gcd_a and gcd_b keep their last value in IDLE/RESP; they are don't-care there.

Optional Feature:
- Macro: GCD_SCHED_TIMEOUT_EN.
- When defined:
  - A counter clears on ISSUE and increments every WAIT cycle.
  - When the count reaches TIMEOUT without gcd_done, go to RESP with resp_result=0 and an extra output resp_err=1.
  - resp_err is 0 for normal responses and resets to 0.
  - The counter width is $clog2(TIMEOUT+1).
- When undefined: there is no counter and no resp_err port, and WAIT holds indefinitely.

Test Plan:
- Single request, requester 2: a=48, b=18; engine returns 6 -> resp_id=2, resp_result=6; gcd_start pulses exactly once.
- Zero bypass: a=0, b=35 -> resp_result=35 two cycles after the grant, gcd_start never asserted. Then a=0, b=0 -> result 0.
- All 4 requesters valid continuously (pairs 12/8, 9/6, 25/15, 7/3) -> grant order 0,1,2,3,0; results 4, 3, 5, 1; rr_ptr wraps from 3 to 0.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_id and resp_result stable; no req_ready pulses; release -> IDLE the next cycle.
- Reset asserted mid-WAIT -> all outputs 0 immediately. A late gcd_done afterward produces no response. The next request is granted to requester 0 first.
- With GCD_SCHED_TIMEOUT_EN and TIMEOUT=20, engine never asserts done -> resp_valid in WAIT cycle 20 with resp_err=1 and resp_result=0.
